image_memory: RTL and testbench
===============================

IMAGE_MEMORY -- requirements
Module: image_memory

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning bits per stored word (8 packed 1-bit pixels).
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, meaning width of both address ports.
REQ-003 SHALL have parameter DEPTH, default 38400, meaning number of stored words (480 rows x 80 bytes per row).
REQ-004 SHALL have port clock, input, 1, the single clock; all state updates occur on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port data, input, DATA_WIDTH, the write data word.
REQ-007 SHALL have port wraddress, input, ADDR_WIDTH, the write address.
REQ-008 SHALL have port wren, input, 1, write enable, active-high.
REQ-009 SHALL have port rdaddress, input, ADDR_WIDTH, the read address; reads are always enabled.
REQ-010 SHALL have port q, output, DATA_WIDTH, the registered read data.

Function
REQ-011 SHALL implement a simple dual-port RAM of DEPTH x DATA_WIDTH, with one write port and one read port, both on clock.
REQ-012 SHALL write data into word wraddress on a rising clock edge when wren=1 and wraddress<DEPTH.
REQ-013 SHALL leave memory unchanged when wren=0.
REQ-014 SHALL ignore writes with wraddress>=DEPTH, with no wrap-around and no aliasing.
REQ-015 SHALL present on q, after each rising edge, the word at the rdaddress sampled on that edge (read latency exactly 1 cycle).
REQ-016 SHALL drive q=0 on the following edge when the sampled rdaddress>=DEPTH.
REQ-017 SHALL return old data on q when a read and a write target the same address on the same edge; the new data is visible on the next read.
REQ-018 SHALL allow simultaneous read and write at different addresses every cycle, with no stalls and no mutual interference.
REQ-019 SHALL hold q stable between edges; a change on rdaddress alone, with no clock edge, SHALL NOT change q.
REQ-020 SHALL initialise all memory words to 0 at power-up or configuration.
REQ-021 SHALL address words linearly; word address = row*80 + (column>>3), with bit 7 holding the leftmost pixel. This is a usage convention only; no address translation occurs inside the block.

Reset
REQ-022 SHALL clear q to 0 immediately on reset assertion, without waiting for a clock edge.
REQ-023 SHALL hold q at 0 while reset=1 and ignore rdaddress during reset.
REQ-024 SHALL retain memory contents across reset; reset SHALL NOT clear the RAM array.
REQ-025 SHALL still perform writes with wren=1 while reset=1, so that image loading is independent of reset.
REQ-026 SHALL resume normal reads on the first rising edge after reset deasserts, with q reflecting the rdaddress sampled on that edge.

Verification
REQ-027 SHALL pass a sequential fill test: write data=i to wraddress=i for i=0..99, one per cycle; then read addresses 0..99 back-to-back -> q=i exactly one cycle after rdaddress=i.
REQ-028 SHALL pass a read-during-write test: address 5 holds 0x05; in one edge, write 0xAA to address 5 while reading address 5 -> q=0x05; the next read of address 5 -> q=0xAA.
REQ-029 SHALL pass a write-enable test: drive wren=0 with data=0xFF at wraddress=10 -> a read of address 10 still returns its prior value (0x0A after the fill).
REQ-030 SHALL pass a boundary test: write 0x3C to address 38399 and 0x77 to address 38400 -> reading 38399 returns 0x3C, reading 38400 returns 0x00, and address 0 is unchanged.
REQ-031 SHALL pass a reset-mid-operation test: during streaming reads, assert reset between edges -> q=0 at once and stays 0; after deassertion, reading address 3 -> q=0x03, confirming contents were retained.
REQ-032 SHALL pass a power-up test: read any never-written address (e.g. 20000) -> q=0x00.

Source files
------------

// File: rtl/image_memory.sv
// Frame-buffer RAM: one write port, one registered read port, single clock.
// Contents power up to zero and survive reset; only the read register is reset.
module image_memory #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 38400
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [ADDR_WIDTH-1:0] wraddress,
  input  logic                  wren,
  input  logic [ADDR_WIDTH-1:0] rdaddress,
  output logic [DATA_WIDTH-1:0] q
);

  localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  // Declaration initialiser gives the all-zero power-up image.
  logic [DATA_WIDTH-1:0] r_mem [DEPTH] = '{default: '0};
  logic [DATA_WIDTH-1:0] r_q;

  logic             w_wr_ok;
  logic             w_rd_ok;
  logic [IDX_W-1:0] w_wr_idx;
  logic [IDX_W-1:0] w_rd_idx;

  // Out-of-range addresses are rejected outright rather than truncated,
  // so no upper address can alias onto a real word.
  assign w_wr_ok  = (32'(wraddress) < DEPTH_U);
  assign w_rd_ok  = (32'(rdaddress) < DEPTH_U);
  assign w_wr_idx = wraddress[IDX_W-1:0];
  assign w_rd_idx = rdaddress[IDX_W-1:0];

  // Write port has no reset so images can be loaded while reset is held.
  always_ff @(posedge clock) begin
    if (wren && w_wr_ok) begin
      r_mem[w_wr_idx] <= data;
    end
  end

  // Same-address read/write returns the old word: the array update is
  // non-blocking and lands after this read samples it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_q <= '0;
    end else if (w_rd_ok) begin
      r_q <= r_mem[w_rd_idx];
    end else begin
      r_q <= '0;
    end
  end

  assign q = r_q;

endmodule

// File: tb/tb_image_memory.sv
// Directed bench for image_memory: expected read data is pushed to a queue
// when each read is driven and popped when q is sampled after the edge.
module tb_image_memory;

  localparam int DW    = 8;
  localparam int AW    = 16;
  localparam int DEPTH = 38400;

  logic          clock = 1'b0;
  logic          reset;
  logic [DW-1:0] data;
  logic [AW-1:0] wraddress;
  logic          wren;
  logic [AW-1:0] rdaddress;
  logic [DW-1:0] q;

  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] model [int];
  int checks = 0;
  int errors = 0;

  image_memory #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .DEPTH     (DEPTH)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .data     (data),
    .wraddress(wraddress),
    .wren     (wren),
    .rdaddress(rdaddress),
    .q        (q)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_rd(input int a);
    if (a < DEPTH && model.exists(a)) return model[a];
    return '0;
  endfunction

  // One clock: drive on the falling edge, predict, sample 1 time unit after rise.
  task automatic cycle(input string tag, input bit we, input int wa,
                       input logic [DW-1:0] wd, input int ra);
    @(negedge clock);
    wren      = we;
    wraddress = AW'(wa);
    data      = wd;
    rdaddress = AW'(ra);
    exp_q.push_back(reset ? '0 : model_rd(ra));
    if (we && wa < DEPTH) model[wa] = wd;
    @(posedge clock);
    #1;
    check(tag, q, exp_q.pop_front());
  endtask

  initial begin
    reset     = 1'b1;
    wren      = 1'b0;
    data      = '0;
    wraddress = '0;
    rdaddress = '0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_q", q, '0);
    @(negedge clock);
    reset = 1'b0;

    // Sequential fill while reading a never-written word.
    for (int i = 0; i < 100; i++) cycle("fill", 1'b1, i, DW'(i), 20000);
    for (int i = 0; i < 100; i++) cycle("readback", 1'b0, 0, '0, i);

    // Read-during-write on address 5.
    cycle("rdw_old", 1'b1, 5, 8'hAA, 5);
    cycle("rdw_new", 1'b0, 0, '0, 5);

    // Write enable low must not disturb address 10.
    cycle("wren_off", 1'b0, 10, 8'hFF, 10);
    cycle("wren_chk", 1'b0, 0, '0, 10);

    // Top-of-array and out-of-range writes/reads.
    cycle("bnd_w_last", 1'b1, DEPTH - 1, 8'h3C, 0);
    cycle("bnd_w_over", 1'b1, DEPTH, 8'h77, DEPTH - 1);
    cycle("bnd_w_max", 1'b1, 65535, 8'h99, DEPTH);
    cycle("bnd_r_max", 1'b0, 0, '0, 65535);
    cycle("bnd_r_last", 1'b0, 0, '0, DEPTH - 1);
    cycle("bnd_r_zero", 1'b0, 0, '0, 0);
    cycle("bnd_r_over", 1'b0, 0, '0, DEPTH);

    // q must hold when rdaddress moves between edges.
    cycle("hold_pre", 1'b0, 0, '0, 3);
    #2;
    rdaddress = AW'(50);
    #1;
    check("hold_q", q, 8'h03);

    // Reset mid-stream: immediate clear, hold at zero, writes still land.
    cycle("stream", 1'b0, 0, '0, 7);
    cycle("stream", 1'b0, 0, '0, 8);
    #2;
    reset = 1'b1;
    #1;
    check("rst_async", q, '0);
    cycle("rst_hold", 1'b1, 200, 8'h5A, 9);
    cycle("rst_hold", 1'b0, 0, '0, 10);
    reset = 1'b0;
    cycle("rst_resume", 1'b0, 0, '0, 3);
    cycle("rst_wr_kept", 1'b0, 0, '0, 200);

    // Power-up contents of untouched words.
    cycle("powerup", 1'b0, 0, '0, 20000);
    cycle("powerup", 1'b0, 0, '0, 30000);

    // Mixed random traffic over a small window plus occasional out-of-range.
    for (int n = 0; n < 300; n++) begin
      int wa;
      int ra;
      wa = ($urandom_range(0, 9) == 0) ? DEPTH + $urandom_range(0, 100) : $urandom_range(0, 127);
      ra = ($urandom_range(0, 9) == 0) ? DEPTH + $urandom_range(0, 100) : $urandom_range(0, 127);
      cycle("random", 1'($urandom_range(0, 1)), wa, DW'($urandom_range(0, 255)), ra);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
